mc_ctrl: RTL
============

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk, rst.
REQ-002 Port clk SHALL be: clk  input  1  system clock; all state updates occur on the rising edge.
REQ-003 Port rst SHALL be: rst  input  1  synchronous active-low reset; sampled on the rising edge of clk.
REQ-004 Port op SHALL be: op  input  6  opcode field (instr[31:26]) from the external instruction register.
REQ-005 Port funct SHALL be: funct  input  6  function field (instr[5:0]) from the external instruction register.
REQ-006 Port zero SHALL be: zero  input  1  ALU equality flag.
REQ-007 Port mem_rdy SHALL be: mem_rdy  input  1  data memory done; ends a load or store access.
REQ-008 Port PCWr SHALL be: PCWr  output  1  PC write enable.
REQ-009 Port IRWr SHALL be: IRWr  output  1  instruction register write enable.
REQ-010 Port RegWr SHALL be: RegWr  output  1  register file write enable.
REQ-011 Port MemWr SHALL be: MemWr  output  1  data memory write enable.
REQ-012 Port ALUSel SHALL be: ALUSel  output  3  ALU operation; 000 add, 001 sub, 010 or, 011 lui.
REQ-013 Port BSel SHALL be: BSel  output  1  ALU B operand; 0 = rb, 1 = extended immediate.
REQ-014 Port ExtOp SHALL be: ExtOp  output  1  extender mode; 0 = zero-extend, 1 = sign-extend.
REQ-015 Port RegDst SHALL be: RegDst  output  2  write register select; 00 rt, 01 rd, 10 $31.
REQ-016 Port RegWSel SHALL be: RegWSel  output  2  write data select; 00 ALU, 01 DM, 10 PC+4.
REQ-017 Port NPCOp SHALL be: NPCOp  output  2  next-PC source; 00 PC+4, 01 branch, 10 jump, 11 jr.
REQ-018 Port state SHALL be: state  output  3  current FSM state, for debug.
REQ-019 Port instr_done SHALL be: instr_done  output  1  one-cycle pulse in the last cycle of each instruction.

Function
REQ-020 The FSM states SHALL be encoded FETCH=000, DCD=001, EXE=010, MEM=011, WB=100; codes 101-111 SHALL return to FETCH on the next cycle with all strobes deasserted.
REQ-021 Instructions SHALL be decoded as follows:
- R-type (op=000000): addu funct=100001, subu funct=100011, jr funct=001000.
- ori op=001101; lw op=100011; sw op=101011; beq op=000100; lui op=001111; j op=000010; jal op=000011.
- Any other op/funct combination is unknown.
REQ-022 All outputs SHALL be combinational functions of state, op, funct, zero and mem_rdy; every strobe not listed for the current state is 0.
REQ-023 FETCH SHALL assert IRWr=1, PCWr=1 and NPCOp=00, then go to DCD.
REQ-024 DCD SHALL resolve jumps and unknowns, then go to FETCH; all other instructions go to EXE:
- j: PCWr=1, NPCOp=10.
- jal: PCWr=1, NPCOp=10, RegWr=1, RegDst=10, RegWSel=10.
- jr: PCWr=1, NPCOp=11.
- unknown: no strobes (treated as a nop).
REQ-025 EXE SHALL drive the ALU per instruction and select the next state:
- addu: ALUSel=000, BSel=0; go to WB.
- subu: ALUSel=001, BSel=0; go to WB.
- ori: ALUSel=010, BSel=1, ExtOp=0; go to WB.
- lui: ALUSel=011, BSel=1, ExtOp=0; go to WB.
- lw/sw: ALUSel=000, BSel=1, ExtOp=1; go to MEM.
- beq: ALUSel=001, BSel=0, NPCOp=01, PCWr=zero; go to FETCH.
REQ-026 MEM SHALL hold ALUSel=000, BSel=1, ExtOp=1 and wait for mem_rdy:
- sw: MemWr=1 in every MEM cycle; go to FETCH when mem_rdy=1.
- lw: go to WB when mem_rdy=1.
- While mem_rdy=0, the FSM stays in MEM with no limit on wait cycles.
REQ-027 WB SHALL assert RegWr=1 and the write-back selects, then go to FETCH:
- R-type: RegDst=01, RegWSel=00.
- ori/lui: RegDst=00, RegWSel=00.
- lw: RegDst=00, RegWSel=01.
REQ-028 instr_done SHALL be 1 in the cycle that precedes a return to FETCH.
REQ-029 Instruction latency with no memory wait SHALL be: j/jal/jr/unknown 2 cycles; beq 3; R-type/ori/lui/sw 4; lw 5.
REQ-030 Each cycle spent with mem_rdy=0 in MEM SHALL add exactly one cycle to the latency of lw/sw.

Reset
REQ-031 When rst=0 at a rising edge of clk, state SHALL become FETCH, regardless of the current state, including MEM mid-wait.
REQ-032 While rst=0, all strobes (PCWr, IRWr, RegWr, MemWr, instr_done) SHALL be forced to 0 and the selects SHALL be 0.
REQ-033 In the first cycle after rst returns to 1, the block SHALL perform a normal FETCH.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- addu (op=0, funct=100001) -> states FETCH, DCD, EXE, WB; in WB: RegWr=1, RegDst=01, RegWSel=00; instr_done=1 in WB.
- lw with mem_rdy held 0 for 2 cycles -> MEM lasts 3 cycles; WB has RegWSel=01; total 7 cycles.
- sw with mem_rdy=1 immediately -> MemWr=1 for exactly 1 cycle; return to FETCH after 4 cycles; RegWr never 1.
- beq with zero=1, then zero=0 -> PCWr=1 with NPCOp=01 in EXE, then PCWr=0 in EXE; 3 cycles each.
- jal -> in DCD: PCWr=1, RegWr=1, RegDst=10, RegWSel=10, NPCOp=10; next state FETCH.
- rst=0 asserted while in MEM waiting -> next state FETCH; MemWr=0 during reset; fetch resumes after release.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: five-state FSM (fetch, decode, execute, memory,
// write-back) that sequences the datapath strobes for a small MIPS subset.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [2:0] ALUSel,
    output logic       BSel,
    output logic       ExtOp,
    output logic [1:0] RegDst,
    output logic [1:0] RegWSel,
    output logic [1:0] NPCOp,
    output logic [2:0] state,
    output logic       instr_done
);
    typedef enum logic [2:0] {
        FETCH = 3'b000,
        DCD   = 3'b001,
        EXE   = 3'b010,
        MEM   = 3'b011,
        WB    = 3'b100
    } state_t;

    state_t state_q, state_d;

    logic is_r, i_addu, i_subu, i_jr, i_ori, i_lw, i_sw, i_beq, i_lui, i_j, i_jal;

    assign is_r   = (op == 6'b000000);
    assign i_addu = is_r && (funct == 6'b100001);
    assign i_subu = is_r && (funct == 6'b100011);
    assign i_jr   = is_r && (funct == 6'b001000);
    assign i_ori  = (op == 6'b001101);
    assign i_lw   = (op == 6'b100011);
    assign i_sw   = (op == 6'b101011);
    assign i_beq  = (op == 6'b000100);
    assign i_lui  = (op == 6'b001111);
    assign i_j    = (op == 6'b000010);
    assign i_jal  = (op == 6'b000011);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= FETCH;
        else      state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d    = FETCH;
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        RegWr      = 1'b0;
        MemWr      = 1'b0;
        ALUSel     = 3'b000;
        BSel       = 1'b0;
        ExtOp      = 1'b0;
        RegDst     = 2'b00;
        RegWSel    = 2'b00;
        NPCOp      = 2'b00;
        instr_done = 1'b0;
        case (state_q)
            FETCH: begin
                IRWr    = 1'b1;
                PCWr    = 1'b1;
                state_d = DCD;
            end
            DCD: begin
                // Jumps and unknown opcodes finish here; everything else executes.
                if (i_j || i_jal || i_jr) begin
                    PCWr  = 1'b1;
                    NPCOp = i_jr ? 2'b11 : 2'b10;
                end
                if (i_jal) begin
                    RegWr   = 1'b1;
                    RegDst  = 2'b10;
                    RegWSel = 2'b10;
                end
                if (i_addu || i_subu || i_ori || i_lui || i_lw || i_sw || i_beq)
                    state_d = EXE;
                else
                    instr_done = 1'b1;
            end
            EXE: begin
                if (i_addu || i_subu) begin
                    ALUSel  = i_subu ? 3'b001 : 3'b000;
                    state_d = WB;
                end else if (i_ori || i_lui) begin
                    ALUSel  = i_lui ? 3'b011 : 3'b010;
                    BSel    = 1'b1;
                    state_d = WB;
                end else if (i_lw || i_sw) begin
                    BSel    = 1'b1;
                    ExtOp   = 1'b1;
                    state_d = MEM;
                end else begin
                    if (i_beq) begin
                        ALUSel = 3'b001;
                        NPCOp  = 2'b01;
                        PCWr   = zero;
                    end
                    instr_done = 1'b1;
                end
            end
            MEM: begin
                BSel  = 1'b1;
                ExtOp = 1'b1;
                MemWr = i_sw;
                if (!mem_rdy && (i_lw || i_sw)) begin
                    state_d = MEM;
                end else if (i_lw) begin
                    state_d = WB;
                end else begin
                    instr_done = 1'b1;
                end
            end
            WB: begin
                RegWr      = 1'b1;
                RegDst     = is_r ? 2'b01 : 2'b00;
                RegWSel    = i_lw ? 2'b01 : 2'b00;
                instr_done = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        // Reset overrides every strobe and select.
        if (!rst) begin
            PCWr       = 1'b0;
            IRWr       = 1'b0;
            RegWr      = 1'b0;
            MemWr      = 1'b0;
            ALUSel     = 3'b000;
            BSel       = 1'b0;
            ExtOp      = 1'b0;
            RegDst     = 2'b00;
            RegWSel    = 2'b00;
            NPCOp      = 2'b00;
            instr_done = 1'b0;
            state_d    = FETCH;
        end
    end
endmodule
